compound_msg_arbiter: RTL and testbench

- Parametrised successor of the single-channel compound-message handshake block.
- Accepts compound messages {mode, x, y} from NUM_CH producer channels, each using sync/notify handshakes.
- Arbitrates round-robin, with the y bit acting as an urgent/priority flag, and buffers winners in a DEPTH-entry FIFO tagged with the source channel.
- Sits between several producer modules and one consumer; the consumer drains via a sync/notify output channel.

---
 rtl/compound_msg_arbiter.sv | 107 ++++++++++
 tb/tb_compound_msg_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/compound_msg_arbiter.sv
// compound_msg_arbiter: round-robin arbiter over NUM_CH sync/notify producers.
// The y bit marks a message as urgent. Winners go into a DEPTH-entry
// first-word-fall-through FIFO, tagged with their source channel.
module compound_msg_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned MSG_W = DATA_W + 2,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*MSG_W-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_sync,
    output logic [NUM_CH-1:0]       in_notify,
    output logic [MSG_W-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_sync,
    output logic                    out_notify,
    output logic [LVL_W-1:0]        level
);

    logic [MSG_W-1:0]    mem_data [DEPTH];
    logic [CH_W-1:0]     mem_ch   [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CH_W-1:0]     rr_ptr;
    logic [NUM_CH-1:0]   urgent, cand;
    logic [2*NUM_CH-1:0] rot;
    logic [CH_W-1:0]     offset, grant;
    logic [CH_W:0]       gsum;
    logic                found, full, push, pop;

    assign full       = (level == LVL_W'(DEPTH));
    assign out_notify = (level != '0);
    assign pop        = out_notify && out_sync;

    // Pick the first candidate at or after rr_ptr; urgent requests mask all others.
    always_comb begin
        urgent = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            urgent[i] = in_data[i*MSG_W];
        end
        cand   = (|(in_sync & urgent)) ? (in_sync & urgent) : in_sync;
        rot    = {cand, cand} >> rr_ptr;
        found  = 1'b0;
        offset = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                offset = CH_W'(k);
            end
        end
        gsum  = {1'b0, rr_ptr} + {1'b0, offset};
        grant = (gsum >= (CH_W+1)'(NUM_CH)) ? CH_W'(gsum - (CH_W+1)'(NUM_CH)) : CH_W'(gsum);
        push  = found && !full && !rst;
        in_notify = push ? (NUM_CH'(1) << grant) : '0;
    end

    // Head of the FIFO is shown only while it holds something.
    always_comb begin
        out_data = '0;
        out_ch   = '0;
        if (out_notify) begin
            out_data = mem_data[rd_ptr];
            out_ch   = mem_ch[rd_ptr];
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data[grant*MSG_W +: MSG_W];
            mem_ch[wr_ptr]   <= grant;
        end
    end

    // Pointers, occupancy and round-robin state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    a_onehot_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(in_notify));
    a_level_bound:  assert property (@(posedge clk) disable iff (rst) level <= LVL_W'(DEPTH));
    a_notify_level: assert property (@(posedge clk) disable iff (rst) out_notify == (level != '0));
    a_no_grant_full: assert property (@(posedge clk) disable iff (rst) full |-> (in_notify == '0));

endmodule

// File: tb/tb_compound_msg_arbiter.sv
// Bench for compound_msg_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of arbitration and FIFO order.
module tb_compound_msg_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int MW  = DW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*MW-1:0] in_data;
    logic [NCH-1:0]    in_sync;
    logic [NCH-1:0]    in_notify;
    logic [MW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              out_sync;
    logic              out_notify;
    logic [2:0]        level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [MW-1:0] m;
        int            c;
    } ent_t;

    ent_t q[$];
    int   rr = 0;

    compound_msg_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .in_notify  (in_notify),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_sync   (out_sync),
        .out_notify (out_notify),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic s, input logic m, input logic [DW-1:0] x,
                          input logic y);
        in_sync[i]          = s;
        in_data[i*MW +: MW] = {m, x, y};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: judge this cycle's outputs, then apply the coming edge.
    always @(negedge clk) begin
        logic [NCH-1:0] exp_notify;
        logic [MW-1:0]  exp_data;
        logic           any_urg, found, do_pop;
        int             g, idx;
        if (rst) begin
            q.delete();
            rr = 0;
            chk("rst_in_notify", 32'(in_notify), 0);
            chk("rst_out_notify", 32'(out_notify), 0);
            chk("rst_level", 32'(level), 0);
        end else begin
            any_urg = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (in_sync[i] && in_data[i*MW]) any_urg = 1'b1;
            end
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < NCH; k++) begin
                idx = (rr + k) % NCH;
                if (!found && in_sync[idx] && (!any_urg || in_data[idx*MW])) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            exp_notify = (found && q.size() < DEP) ? NCH'(1 << g) : '0;
            exp_data   = (q.size() != 0) ? q[0].m : '0;
            chk("m_in_notify", 32'(in_notify), 32'(exp_notify));
            chk("m_out_notify", 32'(out_notify), 32'(q.size() != 0));
            chk("m_level", 32'(level), 32'(q.size()));
            chk("m_out_data", 32'(out_data), 32'(exp_data));
            chk("m_out_ch", 32'(out_ch), (q.size() != 0) ? 32'(q[0].c) : 0);
            do_pop = (q.size() != 0) && out_sync;
            if (do_pop) void'(q.pop_front());
            if (exp_notify != '0) begin
                q.push_back('{m: in_data[g*MW +: MW], c: g});
                rr = (g + 1) % NCH;
            end
        end
    end

    initial begin
        logic [NCH-1:0] gr;
        rst      = 1'b1;
        in_sync  = '0;
        in_data  = '0;
        out_sync = 1'b0;
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b0, 8'(i), 1'b0);

        // 1. Reset holds notify low; release grants channel 0 first.
        repeat (3) cyc();
        @(negedge clk);
        chk("t1_rst_notify", 32'(in_notify), 0);
        chk("t1_rst_level", 32'(level), 0);
        cyc();
        rst      = 1'b0;
        out_sync = 1'b1;

        // 2. Round-robin with all channels requesting and consumer draining.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_grant", 32'(in_notify), 32'(1 << (k % 4)));
            if (k > 0) chk("t2_out_ch", 32'(out_ch), 32'(k - 1));
            chk("t2_level_le1", 32'(level <= 3'd1), 1);
            cyc();
            for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b0, 8'(16 * k + i), 1'b0);
        end

        // 3. Urgent y bit overrides round-robin order.
        in_sync = '0;
        set_ch(3, 1'b1, 1'b0, 8'h33, 1'b0);
        cyc();
        in_sync = '0;
        repeat (3) cyc();
        set_ch(0, 1'b1, 1'b0, 8'h10, 1'b0);
        set_ch(1, 1'b1, 1'b0, 8'h11, 1'b0);
        set_ch(2, 1'b1, 1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t3_urgent_grant", 32'(in_notify), 32'h4);
        cyc();
        set_ch(2, 1'b0, 1'b0, 8'h00, 1'b0);
        set_ch(3, 1'b1, 1'b0, 8'h33, 1'b0);
        @(negedge clk);
        chk("t3_out_data", 32'(out_data), 32'h34B);
        chk("t3_out_ch", 32'(out_ch), 2);
        chk("t3_rr_after", 32'(in_notify), 32'h8);
        cyc();
        in_sync = '0;
        repeat (6) cyc();

        // 4. Fill to full with the consumer stalled; one pop frees one slot.
        out_sync = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            set_ch(1, 1'b1, 1'b0, 8'(n), 1'b0);
            @(negedge clk);
            chk("t4_fill_grant", 32'(in_notify), (n <= 4) ? 32'h2 : 0);
            if (n == 5) chk("t4_full_level", 32'(level), 4);
            cyc();
        end
        out_sync = 1'b1;
        @(negedge clk);
        chk("t4_no_grant_on_pop", 32'(in_notify), 0);
        chk("t4_head_x1", 32'(out_data[DW:1]), 1);
        cyc();
        out_sync = 1'b0;
        @(negedge clk);
        chk("t4_level_after_pop", 32'(level), 3);
        chk("t4_accept_x5", 32'(in_notify), 32'h2);
        chk("t4_head_x2", 32'(out_data[DW:1]), 2);
        cyc();
        in_sync = '0;

        // 5. Simultaneous push and pop holds the level at 2.
        out_sync = 1'b1;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 1'b1, 1'(k), 8'(8'hC0 + k), 1'b0);
            @(negedge clk);
            chk("t5_level_steady", 32'(level), 2);
            cyc();
        end
        in_sync  = '0;
        out_sync = 1'b0;

        // 6. Asynchronous reset mid-cycle discards buffered data.
        set_ch(2, 1'b1, 1'b0, 8'h77, 1'b0);
        cyc();
        @(negedge clk);
        chk("t6_level3", 32'(level), 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_out_notify", 32'(out_notify), 0);
        chk("t6_async_in_notify", 32'(in_notify), 0);
        cyc();
        in_sync  = '0;
        out_sync = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        chk("t6_level_cleared", 32'(level), 0);
        chk("t6_no_old_data", 32'(out_notify), 0);
        cyc();

        // Random traffic: producers hold each offer until it is granted.
        repeat (3000) begin
            @(negedge clk);
            gr = in_notify & in_sync;
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (gr[i] || !in_sync[i]) begin
                    set_ch(i, 1'($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom),
                           1'($urandom_range(0, 3) == 0));
                end
            end
            out_sync = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
